// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB bus definitions: transfer/burst encodings and beat-count helper.
package ahb_slave_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  // Beats in a defined-length burst; 0 means unbounded INCR.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:               return 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_prio_rr_pick.sv
// Combinational winner select: highest priority, ties broken round-robin
// starting just after ptr.
module ahb_prio_rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int PRIO_W      = 1,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS*PRIO_W-1:0] prio,
  input  logic [IDX_W-1:0]              ptr,
  output logic [NUM_MASTERS-1:0]        win_oh,
  output logic [IDX_W-1:0]              win_idx,
  output logic                          win_vld
);

  logic [PRIO_W-1:0]      max_p;
  logic [NUM_MASTERS-1:0] elig;

  // Find the top requesting priority, then scan from ptr+1 for the first
  // requester at that priority.
  always_comb begin
    int j;
    max_p   = '0;
    elig    = '0;
    win_idx = '0;
    win_oh  = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (req[i] && prio[i*PRIO_W +: PRIO_W] > max_p) max_p = prio[i*PRIO_W +: PRIO_W];
    for (int i = 0; i < NUM_MASTERS; i++)
      elig[i] = req[i] && (prio[i*PRIO_W +: PRIO_W] == max_p);
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      j = (int'(ptr) + k) % NUM_MASTERS;
      if (!win_vld && elig[j]) begin
        win_vld    = 1'b1;
        win_idx    = IDX_W'(j);
        win_oh[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: grants one master, locks counted bursts, and
// re-arbitrates only at transfer boundaries.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int PRIO_W      = 1
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [NUM_MASTERS-1:0]           hreq,
  input  logic [NUM_MASTERS*PRIO_W-1:0]    hprior,
  input  logic [NUM_MASTERS*2-1:0]         htrans_m,
  input  logic [NUM_MASTERS*3-1:0]         hburst_m,
  input  logic                             hready,
  output logic [NUM_MASTERS-1:0]           hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0]   hmaster,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   incr_q, incr_d;   // unbounded INCR burst open
  logic [NUM_MASTERS-1:0] hgrant_d;
  logic [IDX_W-1:0]       hmaster_d;
  logic                   busy_d;

  logic [NUM_MASTERS-1:0] win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_vld;

  logic [1:0]             own_trans;
  logic [2:0]             own_burst;
  logic                   own_req;
  logic [4:0]             beats;
  logic                   arb;

  assign own_trans = htrans_m[int'(hmaster)*2 +: 2];
  assign own_burst = hburst_m[int'(hmaster)*3 +: 3];
  assign own_req   = hreq[hmaster];
  assign beats     = burst_beats(own_burst);

  ahb_prio_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .PRIO_W     (PRIO_W),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req    (hreq),
    .prio   (hprior),
    .ptr    (ptr_q),
    .win_oh (win_oh),
    .win_idx(win_idx),
    .win_vld(win_vld)
  );

  // Next-state: detect arbitration points, track burst beats.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    incr_d    = incr_q;
    hgrant_d  = hgrant;
    hmaster_d = hmaster;
    busy_d    = busy;
    arb       = 1'b0;
    case (state_q)
      ST_IDLE: if (|hreq) arb = 1'b1;
      ST_OWNED: if (hready) begin
        if (own_trans == HTRANS_NONSEQ) begin
          if (beats == 5'd0) incr_d = 1'b1;
          else if (beats == 5'd1) arb = 1'b1;
          else begin
            cnt_d   = beats - 5'd1;
            busy_d  = 1'b1;
            incr_d  = 1'b0;
            state_d = ST_BURST;
          end
        end else if (own_trans == HTRANS_IDLE && (incr_q || !own_req)) begin
          arb = 1'b1;
        end
      end
      ST_BURST: if (hready) begin
        if (own_trans == HTRANS_SEQ) begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) arb = 1'b1;
        end else if (own_trans == HTRANS_IDLE) begin
          arb = 1'b1;   // early termination
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (arb) begin
      cnt_d  = '0;
      busy_d = 1'b0;
      incr_d = 1'b0;
      if (win_vld) begin
        state_d   = ST_OWNED;
        hgrant_d  = win_oh;
        hmaster_d = win_idx;
        ptr_d     = win_idx;
      end else begin
        state_d  = ST_IDLE;
        hgrant_d = '0;
      end
    end
  end

  // State, counter, pointer and registered outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      incr_q  <= 1'b0;
      hgrant  <= '0;
      hmaster <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      incr_q  <= incr_d;
      hgrant  <= hgrant_d;
      hmaster <= hmaster_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with hand-computed expectations.
module tb_ahb_slave_arbiter;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [3:0]  hreq;
  logic [3:0]  hprior;
  logic [7:0]  htrans_m;
  logic [11:0] hburst_m;
  logic        hready;
  logic [3:0]  hgrant;
  logic [1:0]  hmaster;
  logic        busy;

  int total = 0;
  int bad   = 0;

  ahb_slave_arbiter #(.NUM_MASTERS(4), .PRIO_W(1)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .hreq    (hreq),
    .hprior  (hprior),
    .htrans_m(htrans_m),
    .hburst_m(hburst_m),
    .hready  (hready),
    .hgrant  (hgrant),
    .hmaster (hmaster),
    .busy    (busy)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_trans(input int m, input logic [1:0] t);
    htrans_m[2*m +: 2] = t;
  endtask

  task automatic set_burst(input int m, input logic [2:0] b);
    hburst_m[3*m +: 3] = b;
  endtask

  task automatic test_reset();
    #1;
    total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL reset_hgrant got=%b want=0000", hgrant); end
    total++; if (hmaster !== 2'd0) begin bad++; $display("FAIL reset_hmaster got=%0d want=0", hmaster); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge hclk);
    hreset = 1'b0;
    hreq = 4'b0001;
    step();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b want=0001", hgrant); end
    total++; if (hmaster !== 2'd0) begin bad++; $display("FAIL first_hmaster got=%0d want=0", hmaster); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_busy got=%b want=0", busy); end
  endtask

  task automatic test_priority();
    hreq = 4'b1111; hprior = 4'b0100;
    step();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL no_preempt_owned got=%b want=0001", hgrant); end
    hreq = 4'b1110;   // master 0 releases while idle
    step();
    total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL prio_grant got=%b want=0100", hgrant); end
    total++; if (hmaster !== 2'd2) begin bad++; $display("FAIL prio_hmaster got=%0d want=2", hmaster); end
    hreq = 4'b1011;
    set_burst(2, 3'd0); set_trans(2, 2'd2);   // SINGLE NONSEQ
    step();
    set_trans(2, 2'd0);
    total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL rr_after_single got=%b want=1000", hgrant); end
    total++; if (hmaster !== 2'd3) begin bad++; $display("FAIL rr_hmaster got=%0d want=3", hmaster); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
  endtask

  task automatic test_burst_lock();
    hreq = 4'b0011; hprior = 4'b0000;   // master 3 releases while idle
    step();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL handover_m0 got=%b want=0001", hgrant); end
    hprior = 4'b0010;
    set_burst(0, 3'd5); set_trans(0, 2'd2);   // INCR8 NONSEQ
    step();
    total++; if (busy !== 1'b1 || hgrant !== 4'b0001) begin bad++; $display("FAIL incr8_beat1 got=%b/%b want=1/0001", busy, hgrant); end
    set_trans(0, 2'd3);
    for (int b = 2; b <= 8; b++) begin
      if (b == 3 || b == 5) begin
        hready = 1'b0;
        step();
        total++; if (busy !== 1'b1 || hgrant !== 4'b0001) begin bad++; $display("FAIL incr8_wait%0d got=%b/%b want=1/0001", b, busy, hgrant); end
        hready = 1'b1;
      end
      step();
      if (b < 8) begin
        total++; if (busy !== 1'b1 || hgrant !== 4'b0001) begin bad++; $display("FAIL incr8_beat%0d got=%b/%b want=1/0001", b, busy, hgrant); end
      end else begin
        total++; if (hgrant !== 4'b0010 || hmaster !== 2'd1 || busy !== 1'b0) begin bad++; $display("FAIL incr8_end got=%b/%0d/%b want=0010/1/0", hgrant, hmaster, busy); end
      end
    end
    set_trans(0, 2'd0);
  endtask

  task automatic test_early_term();
    set_burst(1, 3'd6); set_trans(1, 2'd2);   // WRAP16 NONSEQ
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap16_busy got=%b want=1", busy); end
    set_trans(1, 2'd3);
    for (int b = 2; b <= 4; b++) step();
    total++; if (busy !== 1'b1 || hgrant !== 4'b0010) begin bad++; $display("FAIL wrap16_beat4 got=%b/%b want=1/0010", busy, hgrant); end
    hreq = 4'b1011; hprior = 4'b0000;
    set_trans(1, 2'd0);
    step();
    total++; if (hgrant !== 4'b1000 || hmaster !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL early_term got=%b/%0d/%b want=1000/3/0", hgrant, hmaster, busy); end
  endtask

  task automatic test_incr();
    hreq = 4'b1001; hprior = 4'b0001;
    set_burst(3, 3'd1); set_trans(3, 2'd2);   // INCR NONSEQ
    step();
    total++; if (busy !== 1'b0 || hgrant !== 4'b1000) begin bad++; $display("FAIL incr_beat1 got=%b/%b want=0/1000", busy, hgrant); end
    set_trans(3, 2'd3);
    for (int b = 2; b <= 20; b++) begin
      step();
      total++; if (busy !== 1'b0 || hgrant !== 4'b1000) begin bad++; $display("FAIL incr_beat%0d got=%b/%b want=0/1000", b, busy, hgrant); end
    end
    set_trans(3, 2'd0);
    step();
    total++; if (hgrant !== 4'b0001 || hmaster !== 2'd0) begin bad++; $display("FAIL incr_handover got=%b/%0d want=0001/0", hgrant, hmaster); end
    hreq = 4'b0001; hprior = 4'b0000;
  endtask

  task automatic test_async_reset();
    set_burst(0, 3'd3); set_trans(0, 2'd2);   // INCR4 NONSEQ
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL incr4_busy got=%b want=1", busy); end
    set_trans(0, 2'd3);
    step();
    #2 hreset = 1'b1;
    #1;
    total++; if (hgrant !== 4'b0000 || busy !== 1'b0 || hmaster !== 2'd0) begin bad++; $display("FAIL async_reset got=%b/%b/%0d want=0000/0/0", hgrant, busy, hmaster); end
    @(negedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    htrans_m = '0; hreq = 4'b0110; hprior = 4'b0000;
    step();
    total++; if (hgrant !== 4'b0010 || hmaster !== 2'd1) begin bad++; $display("FAIL post_reset_tie got=%b/%0d want=0010/1", hgrant, hmaster); end
  endtask

  task automatic test_idle_return();
    hreq = 4'b0000;
    step();
    total++; if (hgrant !== 4'b0000 || hmaster !== 2'd1) begin bad++; $display("FAIL to_idle got=%b/%0d want=0000/1", hgrant, hmaster); end
    hreq = 4'b0100; hready = 1'b0;
    step();
    total++; if (hgrant !== 4'b0100 || hmaster !== 2'd2) begin bad++; $display("FAIL idle_grant_no_hready got=%b/%0d want=0100/2", hgrant, hmaster); end
    hready = 1'b1;
  endtask

  initial begin
    hreset = 1'b1; hreq = '0; hprior = '0; htrans_m = '0; hburst_m = '0; hready = 1'b1;
    test_reset();
    test_priority();
    test_burst_lock();
    test_early_term();
    test_incr();
    test_async_reset();
    test_idle_return();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
